// File: rtl/axi_stream_input.sv
// AXI-Stream character receiver: FWFT FIFO, N-character sequence unpacker and
// batch-boundary TLAST checker feeding the training compute core.

module fifo #(
  parameter int DEPTH    = 1024,
  parameter int WIDTH    = 9,
  parameter int LOG_SIZE = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [WIDTH-1:0] i_data_w,
  output logic [WIDTH-1:0] o_data_r,
  output logic             o_empty,
  output logic             o_full
);
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [LOG_SIZE:0] r_wr_ptr;
  logic [LOG_SIZE:0] r_rd_ptr;
  logic              w_do_wr;
  logic              w_do_rd;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[LOG_SIZE] != r_rd_ptr[LOG_SIZE]) &&
                    (r_wr_ptr[LOG_SIZE-1:0] == r_rd_ptr[LOG_SIZE-1:0]);
  assign w_do_wr  = i_we & ~o_full;
  assign w_do_rd  = i_re & ~o_empty;
  assign o_data_r = r_mem[r_rd_ptr[LOG_SIZE-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[LOG_SIZE-1:0]] <= i_data_w;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module axi_stream_input #(
  parameter int                   FIFO_SIZE  = 1024,
  parameter int                   LOG_SIZE   = 10,
  parameter int                   N          = 8,
  parameter int                   CHAR_LEN   = 8,
  parameter int                   BATCH_SIZE = 4,
  parameter int                   STATE_LEN  = 3,
  parameter logic [STATE_LEN-1:0] M_FIN      = 3'd5
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [CHAR_LEN-1:0]   S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  run,
  input  logic [STATE_LEN-1:0]  state,
  output logic [N*CHAR_LEN-1:0] d,
  output logic                  valid,
  output logic                  last_err,
  output logic                  empty
);
  localparam int                  C1W     = ($clog2(N+1) > 4) ? $clog2(N+1) : 4;
  localparam logic [C1W-1:0]      C1_FULL = C1W'(N);
  localparam logic [LOG_SIZE-1:0] C2_LAST = LOG_SIZE'(BATCH_SIZE*N-1);

  logic [C1W-1:0]      r_count1;
  logic [LOG_SIZE-1:0] r_count2;
  logic [N*CHAR_LEN-1:0] r_d;
  logic                r_last_err;
  logic [CHAR_LEN:0]   w_data_r;
  logic                w_full;
  logic                w_empty;
  logic                w_re;
  logic                w_mism;
  logic                w_fin;

  fifo #(
    .DEPTH   (FIFO_SIZE),
    .WIDTH   (CHAR_LEN+1),
    .LOG_SIZE(LOG_SIZE)
  ) u_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_we    (S_AXIS_TVALID),
    .i_re    (w_re),
    .i_data_w({S_AXIS_TLAST, S_AXIS_TDATA}),
    .o_data_r(w_data_r),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign S_AXIS_TREADY = ~w_full;
  assign empty         = w_empty;
  assign valid         = (r_count1 == C1_FULL);
  assign d             = r_d;
  assign last_err      = r_last_err;
  assign w_re          = run & ~w_empty & (r_count1 != C1_FULL);
  assign w_fin         = (state == M_FIN);
  // Host TLAST must coincide exactly with the final character of each batch.
  assign w_mism        = w_re & (w_data_r[CHAR_LEN] != (r_count2 == C2_LAST));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_count1   <= '0;
      r_count2   <= '0;
      r_d        <= '0;
      r_last_err <= 1'b0;
    end else begin
      if (w_re) begin
        for (int i = 0; i < N; i++) begin
          if (r_count1 == C1W'(i)) r_d[i*CHAR_LEN +: CHAR_LEN] <= w_data_r[CHAR_LEN-1:0];
        end
        r_count1 <= r_count1 + 1'b1;
      end else if (!run) begin
        r_count1 <= '0;
      end

      if (w_re)       r_count2 <= (r_count2 == C2_LAST) ? '0 : r_count2 + 1'b1;
      else if (w_fin) r_count2 <= '0;

      if (w_mism)     r_last_err <= 1'b1;
      else if (w_fin) r_last_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_stream_input.sv
// Bench for axi_stream_input: directed scenarios plus randomized traffic,
// checked against a queue-based model of the receive stage.

module tb_axi_stream_input;
  localparam int N = 8, CHAR_LEN = 8, BATCH_SIZE = 4, STATE_LEN = 3;
  localparam int FIFO_SIZE = 1024, LOG_SIZE = 10;
  localparam logic [STATE_LEN-1:0] M_FIN = 3'd5;
  localparam int BN = BATCH_SIZE*N;

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [CHAR_LEN-1:0] S_AXIS_TDATA = '0;
  logic S_AXIS_TLAST = 1'b0, S_AXIS_TVALID = 1'b0, run = 1'b0;
  logic [STATE_LEN-1:0] state = '0;
  wire S_AXIS_TREADY, valid, last_err, empty;
  wire [N*CHAR_LEN-1:0] d;

  int n_cmp = 0, n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi_stream_input #(
    .FIFO_SIZE(FIFO_SIZE), .LOG_SIZE(LOG_SIZE), .N(N), .CHAR_LEN(CHAR_LEN),
    .BATCH_SIZE(BATCH_SIZE), .STATE_LEN(STATE_LEN), .M_FIN(M_FIN)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .run(run), .state(state),
    .d(d), .valid(valid), .last_err(last_err), .empty(empty)
  );

  // Reference model: FIFO as a queue, sequence fill level, batch position, error flag.
  logic [CHAR_LEN:0]     m_q[$];
  logic [N*CHAR_LEN-1:0] m_d;
  int                    m_n, m_pos, m_sz0;
  bit                    m_err, m_pop, m_mism;
  logic [CHAR_LEN:0]     m_w;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_q.delete(); m_d = '0; m_n = 0; m_pos = 0; m_err = 0;
    end else begin
      m_sz0  = m_q.size();
      m_pop  = run && (m_sz0 > 0) && (m_n < N);
      m_mism = 0;
      if (m_pop) begin
        m_w = m_q.pop_front();
        m_d[m_n*CHAR_LEN +: CHAR_LEN] = m_w[CHAR_LEN-1:0];
        m_n++;
        m_mism = (m_w[CHAR_LEN] != (m_pos == BN-1));
        m_pos  = (m_pos + 1) % BN;
      end else if (state == M_FIN) begin
        m_pos = 0;
      end
      if (m_mism) m_err = 1;
      else if (state == M_FIN) m_err = 0;
      if (!m_pop && !run) m_n = 0;
      if (S_AXIS_TVALID && m_sz0 < FIFO_SIZE) m_q.push_back({S_AXIS_TLAST, S_AXIS_TDATA});
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; run = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; state = '0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (S_AXIS_TREADY !== 1'b1) begin n_bad++; $display("FAIL reset_tready got %b want 1", S_AXIS_TREADY); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL reset_last_err got %b want 0", last_err); end
    n_cmp++; if (d !== '0) begin n_bad++; $display("FAIL reset_d got %h want 0", d); end
  endtask

  task automatic test_one_sequence();
    logic [N*CHAR_LEN-1:0] held;
    for (int i = 0; i < N; i++) begin
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = CHAR_LEN'(i+1); S_AXIS_TLAST = 1'b0;
      tick();
    end
    S_AXIS_TVALID = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= N; k++) begin
      tick();
      n_cmp++; if (valid !== (k == N)) begin n_bad++; $display("FAIL seq_valid_cycle%0d got %b want %b", k, valid, (k == N)); end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (d[i*CHAR_LEN +: CHAR_LEN] !== CHAR_LEN'(i+1)) begin
        n_bad++; $display("FAIL seq_slot%0d got %0d want %0d", i, d[i*CHAR_LEN +: CHAR_LEN], i+1);
      end
    end
    held = d;
    run = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL seq_drop_valid got %b want 0", valid); end
    n_cmp++; if (d !== held) begin n_bad++; $display("FAIL seq_hold_d got %h want %h", d, held); end
  endtask

  task automatic test_dry_stall();
    logic [CHAR_LEN-1:0] ch [N];
    run = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      ch[i] = CHAR_LEN'($urandom);
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = ch[i]; S_AXIS_TLAST = 1'b0;
      tick();
      S_AXIS_TVALID = 1'b0;
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid_push%0d got %b want 0", i, valid); end
      tick();
      n_cmp++; if (valid !== (i == N-1)) begin n_bad++; $display("FAIL stall_valid_pop%0d got %b want %b", i, valid, (i == N-1)); end
      if (i != N-1) tick();
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (d[i*CHAR_LEN +: CHAR_LEN] !== ch[i]) begin
        n_bad++; $display("FAIL stall_slot%0d got %h want %h", i, d[i*CHAR_LEN +: CHAR_LEN], ch[i]);
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_full();
    logic [CHAR_LEN-1:0] extra;
    int nseq;
    run = 1'b0;
    for (int i = 0; i < FIFO_SIZE; i++) begin
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = CHAR_LEN'($urandom); S_AXIS_TLAST = 1'b0;
      tick();
      if (i == FIFO_SIZE-2) begin
        n_cmp++; if (S_AXIS_TREADY !== 1'b1) begin n_bad++; $display("FAIL full_tready_1023 got %b want 1", S_AXIS_TREADY); end
      end
    end
    n_cmp++; if (S_AXIS_TREADY !== 1'b0) begin n_bad++; $display("FAIL full_tready_1024 got %b want 0", S_AXIS_TREADY); end
    extra = CHAR_LEN'($urandom);
    S_AXIS_TDATA = extra;
    repeat (2) tick();
    n_cmp++; if (S_AXIS_TREADY !== 1'b0) begin n_bad++; $display("FAIL full_held_off got %b want 0", S_AXIS_TREADY); end
    run = 1'b1;
    tick();
    run = 1'b0;
    n_cmp++; if (S_AXIS_TREADY !== 1'b1) begin n_bad++; $display("FAIL full_after_pop got %b want 1", S_AXIS_TREADY); end
    tick();
    S_AXIS_TVALID = 1'b0;
    n_cmp++; if (S_AXIS_TREADY !== 1'b0) begin n_bad++; $display("FAIL full_extra_accepted got %b want 0", S_AXIS_TREADY); end
    nseq = 0;
    while (empty !== 1'b1 && nseq < 200) begin
      run = 1'b1;
      for (int k = 0; k < N+4 && valid !== 1'b1; k++) tick();
      n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL drain_timeout seq %0d valid %b want 1", nseq, valid); end
      n_cmp++; if (d !== m_d) begin n_bad++; $display("FAIL drain_d seq %0d got %h want %h", nseq, d, m_d); end
      run = 1'b0;
      tick();
      nseq++;
    end
    n_cmp++; if (nseq !== FIFO_SIZE/N) begin n_bad++; $display("FAIL drain_count got %0d want %0d", nseq, FIFO_SIZE/N); end
    n_cmp++; if (d[(N-1)*CHAR_LEN +: CHAR_LEN] !== extra) begin
      n_bad++; $display("FAIL full_extra_data got %h want %h", d[(N-1)*CHAR_LEN +: CHAR_LEN], extra);
    end
  endtask

  task automatic test_tlast();
    state = M_FIN; tick(); state = '0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < BN; i++) begin
        S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = CHAR_LEN'($urandom);
        S_AXIS_TLAST = (b < 2) ? (i == BN-1) : (i == 0);
        tick();
      end
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      for (int s = 0; s < BATCH_SIZE; s++) begin
        run = 1'b1;
        tick();
        if (b == 2 && s == 0) begin
          n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL tlast_early got %b want 1", last_err); end
        end
        for (int k = 0; k < N+4 && valid !== 1'b1; k++) tick();
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL tlast_timeout b%0d s%0d valid %b want 1", b, s, valid); end
        n_cmp++; if (d !== m_d) begin n_bad++; $display("FAIL tlast_d b%0d s%0d got %h want %h", b, s, d, m_d); end
        n_cmp++; if (last_err !== m_err) begin n_bad++; $display("FAIL tlast_model b%0d s%0d got %b want %b", b, s, last_err, m_err); end
        if (b < 2) begin
          n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL tlast_ok b%0d s%0d got %b want 0", b, s, last_err); end
        end
        run = 1'b0;
        tick();
      end
    end
    n_cmp++; if (last_err !== 1'b1) begin n_bad++; $display("FAIL tlast_sticky got %b want 1", last_err); end
    state = M_FIN; tick(); state = '0;
    n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL tlast_fin_clear got %b want 0", last_err); end
  endtask

  task automatic test_reset_mid();
    logic [CHAR_LEN-1:0] ch [N];
    for (int i = 0; i < N; i++) begin
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = CHAR_LEN'($urandom); S_AXIS_TLAST = 1'b0;
      tick();
    end
    S_AXIS_TVALID = 1'b0;
    run = 1'b1;
    repeat (N/2) tick();
    ARESET = 1'b1;
    #1;
    n_cmp++; if (S_AXIS_TREADY !== 1'b1) begin n_bad++; $display("FAIL rmid_tready got %b want 1", S_AXIS_TREADY); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty got %b want 1", empty); end
    n_cmp++; if (d !== '0) begin n_bad++; $display("FAIL rmid_d got %h want 0", d); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", valid); end
    n_cmp++; if (last_err !== 1'b0) begin n_bad++; $display("FAIL rmid_last_err got %b want 0", last_err); end
    run = 1'b0;
    @(posedge ACLK); #1 ARESET = 1'b0;
    for (int i = 0; i < N; i++) begin
      ch[i] = CHAR_LEN'($urandom);
      S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = ch[i];
      tick();
    end
    S_AXIS_TVALID = 1'b0;
    run = 1'b1;
    for (int k = 0; k < N+4 && valid !== 1'b1; k++) tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh_timeout valid %b want 1", valid); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (d[i*CHAR_LEN +: CHAR_LEN] !== ch[i]) begin
        n_bad++; $display("FAIL rmid_slot%0d got %h want %h", i, d[i*CHAR_LEN +: CHAR_LEN], ch[i]);
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      S_AXIS_TVALID = ($urandom_range(0, 2) != 0);
      S_AXIS_TDATA  = CHAR_LEN'($urandom);
      S_AXIS_TLAST  = ($urandom_range(0, 15) == 0);
      state         = ($urandom_range(0, 40) == 0) ? M_FIN : '0;
      if (!run) run = ($urandom_range(0, 3) == 0);
      else if (valid === 1'b1) begin
        if ($urandom_range(0, 1) == 0) run = 1'b0;
      end else if ($urandom_range(0, 30) == 0) run = 1'b0;
      tick();
      n_cmp++; if (valid !== (m_n == N)) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, valid, (m_n == N)); end
      n_cmp++; if (empty !== (m_q.size() == 0)) begin n_bad++; $display("FAIL rnd_empty c%0d got %b want %b", c, empty, (m_q.size() == 0)); end
      n_cmp++; if (S_AXIS_TREADY !== (m_q.size() < FIFO_SIZE)) begin n_bad++; $display("FAIL rnd_tready c%0d got %b", c, S_AXIS_TREADY); end
      n_cmp++; if (last_err !== m_err) begin n_bad++; $display("FAIL rnd_last_err c%0d got %b want %b", c, last_err, m_err); end
      n_cmp++; if (d !== m_d) begin n_bad++; $display("FAIL rnd_d c%0d got %h want %h", c, d, m_d); end
    end
    S_AXIS_TVALID = 1'b0; run = 1'b0; state = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_one_sequence();
    test_dry_stall();
    test_full();
    test_reset();
    test_tlast();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_stream_input.md
# axi_stream_input

Receive stage at the front of the training datapath. It accepts a stream of `CHAR_LEN`-bit characters on an AXI Stream slave port and buffers them in an internal FIFO. On request it unpacks one sequence of `N` characters into a flat `N*CHAR_LEN` vector for the compute core. It tracks batch position and flags any disagreement between the host's `TLAST` and the expected batch boundary.

## Interface
- `FIFO_SIZE`, 1024: depth of the internal character FIFO.
- `LOG_SIZE`, 10: log2 of `FIFO_SIZE`.
- Widths and constants come from `consts_train.vh`: `N`, `CHAR_LEN`, `BATCH_SIZE`, `STATE_LEN`, `M_FIN`.

Ports:
- `ACLK` in 1: the single clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `S_AXIS_TDATA` in `CHAR_LEN`: input character.
- `S_AXIS_TLAST` in 1: host marks the last character of a batch.
- `S_AXIS_TVALID` in 1: source has data.
- `S_AXIS_TREADY` out 1: block can accept data.
- `run` in 1: request to assemble one sequence; held high until `valid` has been consumed.
- `state` in `STATE_LEN`: global controller state.
- `d` out `N*CHAR_LEN`: assembled sequence. Character i occupies bits `[i*CHAR_LEN +: CHAR_LEN]`.
- `valid` out 1: `d` holds a complete sequence.
- `last_err` out 1: sticky flag for a `TLAST` mismatch.
- `empty` out 1: internal FIFO is empty.

## Operation
- **FIFO:** instance of the existing `fifo` module.
  - Width is `1+CHAR_LEN`; the word written is `{S_AXIS_TLAST, S_AXIS_TDATA}`.
  - Read data is first-word-fall-through: `data_r` is valid whenever `empty` is low.
- **Write side:**
  - `S_AXIS_TREADY = ~full`.
  - A write occurs when `S_AXIS_TVALID & S_AXIS_TREADY`.
- **Read side:**
  - `re = run & ~empty & (count1 != N)`.
  - On each `re`: `d` slot `[count1] <= data_r[CHAR_LEN-1:0]`, and `count1` increments.
- **`count1`** (4+ bits, sized to hold `N`), in priority order:
  1. Increments on `re`.
  2. Otherwise holds while `run` is high.
  3. Otherwise clears to 0.
- **Outputs from `count1`:** `valid = (count1 == N)`. `d` is not cleared when `run` drops; it holds the last sequence.
- **`count2`** (`LOG_SIZE` bits, covers `BATCH_SIZE*N`), in priority order:
  1. On `re`: wraps to 0 if it equals `BATCH_SIZE*N-1`, otherwise increments.
  2. Else if `state == M_FIN`: clears to 0.
  3. Else holds.
- **`last_err`:**
  - Set on `re` when `data_r[CHAR_LEN] != (count2 == BATCH_SIZE*N-1)`.
  - Cleared when `state == M_FIN` and no mismatching `re` occurs in that cycle; a set in the same cycle wins.
  - Otherwise holds.
- **Other outputs:** `empty` is the FIFO empty flag, unregistered.

## Timing
- Reset values:
  - `count1 = 0`, `count2 = 0`, `d = 0`, `last_err = 0`.
  - FIFO pointers cleared, so `empty = 1`, `S_AXIS_TREADY = 1`, `valid = 0`.
- `S_AXIS_TREADY` is combinational from FIFO `full`. It drops the cycle after the write that fills the FIFO.
- A write that lands in an empty FIFO is visible at `data_r` and `~empty` on the next cycle. It can be popped then.
- `valid` rises the cycle after the N-th pop. With the FIFO holding at least `N` words and `run` rising at cycle 0, pops occur in cycles 0..N-1 and `valid` is high from cycle N.
- If the FIFO runs dry mid-sequence, `re` stalls and `count1` holds. Popping resumes the cycle data appears; no character is skipped or duplicated.
- Simultaneous write and read are legal in one cycle, including when the FIFO holds one word. A write is never accepted while full, even if a read occurs in the same cycle.
- Dropping `run` before `valid` aborts the sequence:
  - `count1` clears the next cycle.
  - Characters already popped are lost.
  - `count2` keeps its position.
- Asserting `ARESET` mid-operation clears all state immediately, including FIFO contents. `S_AXIS_TREADY` goes high asynchronously.

## Test plan
- **Reset.** Assert `ARESET` for 3 cycles, then release.
  - `empty=1`, `TREADY=1`, `valid=0`, `last_err=0`, `d=0`.
- **One sequence, in order.** Push characters 1..N with no `TLAST`, then raise `run`.
  - `valid` rises N cycles later.
  - `d` slot i equals i+1.
  - Drop `run`: `valid=0` next cycle and `d` unchanged.
- **Dry FIFO stall.** Raise `run` with an empty FIFO, then push one character every 3 cycles.
  - `valid` rises the cycle after the N-th push becomes visible.
  - `d` order is preserved.
- **Full FIFO.** Push 1024 characters with `run` low.
  - `TREADY=0` after the 1024th.
  - The 1025th is held off until one pop, then accepted.
- **TLAST checking.** Stream `BATCH_SIZE*N` characters with `TLAST` only on the last one and run `BATCH_SIZE` sequences.
  - `last_err` stays 0 and `count2` wraps to 0.
  - Repeat with `TLAST` on character 0: `last_err=1` after the first pop.
  - `state=M_FIN` clears it.
- **Reset mid-sequence.** Assert `ARESET` after N/2 pops.
  - All outputs return to reset values.
  - A fresh sequence afterwards assembles correctly.
